// File: rtl/seq_pkg.sv
// Shared types and constants for the datapath sequencer: states, opcodes, ULA codes, field positions.
// SEQ_SINGLE_STEP_EN adds the WAIT state used for single-step execution.
package seq_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned RA_W    = 3;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CTRL_W  = 3;
  localparam int unsigned OFF_W   = 5;

  // Instruction field positions
  localparam int unsigned OP_LSB   = 14;
  localparam int unsigned HALT_BIT = 13;
  localparam int unsigned RD_LSB   = 11;
  localparam int unsigned RS_LSB   = 8;
  localparam int unsigned RT_LSB   = 5;
  localparam int unsigned FUNC_LSB = 0;
  localparam int unsigned IMM_LSB  = 0;
  localparam int unsigned OFF_LSB  = 0;

  localparam logic [CTRL_W-1:0] ALU_AND  = 3'b000;
  localparam logic [CTRL_W-1:0] ALU_OR   = 3'b001;
  localparam logic [CTRL_W-1:0] ALU_ADD  = 3'b010;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 3'b110;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 3'b111;
  localparam logic [CTRL_W-1:0] ADD_CTRL = ALU_ADD;
  localparam logic [CTRL_W-1:0] SUB_CTRL = ALU_SUB;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
`ifdef SEQ_SINGLE_STEP_EN
    ,
    ST_WAIT   = 3'd6
`endif
  } state_e;

  typedef enum logic [1:0] {
    OP_R   = 2'b00,
    OP_I   = 2'b01,
    OP_BEQ = 2'b10,
    OP_SYS = 2'b11
  } op_e;

  typedef struct packed {
    op_e                 op;
    logic                is_halt;
    logic [RA_W-1:0]     ra1;
    logic [RA_W-1:0]     ra2;
    logic [RA_W-1:0]     wa3;
    logic [CTRL_W-1:0]   alu_ctrl;
    logic                alu_src;
    logic [DATA_W-1:0]   imm;
    logic [PC_W-1:0]     br_off;
    logic [PC_W-1:0]     jmp_target;
  } dec_t;

endpackage

// File: rtl/datapath_sequencer_if.sv
// Sequencer <-> ROM / register file / SrcB mux / ULA signal bundle.
interface datapath_sequencer_if;
  import seq_pkg::*;

  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr;
  logic [RA_W-1:0]    rf_ra1;
  logic [RA_W-1:0]    rf_ra2;
  logic [RA_W-1:0]    rf_wa3;
  logic               rf_we3;
  logic [CTRL_W-1:0]  alu_ctrl;
  logic               alu_src;
  logic [DATA_W-1:0]  imm;
  logic               alu_zero;

  modport master (
    output pc, rf_ra1, rf_ra2, rf_wa3, rf_we3, alu_ctrl, alu_src, imm,
    input  instr, alu_zero
  );

  modport slave (
    input  pc, rf_ra1, rf_ra2, rf_wa3, rf_we3, alu_ctrl, alu_src, imm,
    output instr, alu_zero
  );

endinterface

// File: rtl/seq_decode.sv
// Combinational instruction decode: splits an instruction word into datapath controls and pc operands.
module seq_decode
  import seq_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output dec_t               dec
);

  always_comb begin
    dec            = '0;
    dec.op         = op_e'(ir[OP_LSB +: 2]);
    dec.is_halt    = ir[HALT_BIT];
    dec.ra1        = ir[RS_LSB +: RA_W];
    dec.ra2        = ir[RT_LSB +: RA_W];
    dec.wa3        = ir[RD_LSB +: RA_W];
    dec.imm        = ir[IMM_LSB +: DATA_W];
    dec.br_off     = {{(PC_W-OFF_W){ir[OFF_LSB+OFF_W-1]}}, ir[OFF_LSB +: OFF_W]};
    dec.jmp_target = ir[PC_W-1:0];
    // BEQ compares by subtracting; I-type adds the immediate
    unique case (dec.op)
      OP_R:    begin dec.alu_ctrl = ir[FUNC_LSB +: CTRL_W]; dec.alu_src = 1'b0; end
      OP_I:    begin dec.alu_ctrl = ADD_CTRL;               dec.alu_src = 1'b1; end
      OP_BEQ:  begin dec.alu_ctrl = SUB_CTRL;               dec.alu_src = 1'b0; end
      default: begin dec.alu_ctrl = ADD_CTRL;               dec.alu_src = 1'b0; end
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control FSM and pc for the register file / SrcB mux / ULA datapath.
// Define SEQ_SINGLE_STEP_EN to add the step input and a WAIT state between instructions.
module datapath_sequencer
  import seq_pkg::*;
(
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                 step,
`endif
  datapath_sequencer_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           state_dbg
);

  state_e             state_q, state_nx, resume_st;
  logic [PC_W-1:0]    pc_q, pc_nx;
  logic [INSTR_W-1:0] ir_q, ir_nx, ir_view;
  logic [RA_W-1:0]    ra1_q, ra1_nx, ra2_q, ra2_nx, wa3_q, wa3_nx;
  logic               we3_q, we3_nx;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_nx;
  logic               src_q, src_nx;
  logic [DATA_W-1:0]  imm_q, imm_nx;
  logic               busy_q, busy_nx, done_q, done_nx;
  dec_t               dec;

  // Controls are loaded on leaving DECODE, so decode the ROM word directly in that state
  assign ir_view = (state_q == ST_DECODE) ? bus.instr : ir_q;

  seq_decode u_decode (
    .ir  (ir_view),
    .dec (dec)
  );

`ifdef SEQ_SINGLE_STEP_EN
  logic step_q, step_rise;
  assign step_rise = step & ~step_q;
  assign resume_st = ST_WAIT;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) step_q <= 1'b0;
    else         step_q <= step;
  end
`else
  assign resume_st = ST_FETCH;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      wa3_q   <= '0;
      we3_q   <= 1'b0;
      ctrl_q  <= ADD_CTRL;
      src_q   <= 1'b0;
      imm_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      pc_q    <= pc_nx;
      ir_q    <= ir_nx;
      ra1_q   <= ra1_nx;
      ra2_q   <= ra2_nx;
      wa3_q   <= wa3_nx;
      we3_q   <= we3_nx;
      ctrl_q  <= ctrl_nx;
      src_q   <= src_nx;
      imm_q   <= imm_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    pc_nx    = pc_q;
    ir_nx    = ir_q;
    ra1_nx   = ra1_q;
    ra2_nx   = ra2_q;
    wa3_nx   = wa3_q;
    we3_nx   = 1'b0;
    ctrl_nx  = ctrl_q;
    src_nx   = src_q;
    imm_nx   = imm_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_nx    = '0;
          state_nx = ST_FETCH;
        end
      end
      ST_FETCH: state_nx = ST_DECODE;
      ST_DECODE: begin
        ir_nx = bus.instr;
        if (dec.op == OP_SYS) begin
          if (dec.is_halt) begin
            state_nx = ST_HALT;
          end else begin
            pc_nx    = dec.jmp_target;
            state_nx = resume_st;
          end
        end else begin
          ra1_nx   = dec.ra1;
          ra2_nx   = dec.ra2;
          wa3_nx   = dec.wa3;
          ctrl_nx  = dec.alu_ctrl;
          src_nx   = dec.alu_src;
          imm_nx   = dec.imm;
          state_nx = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (dec.op == OP_BEQ) begin
          pc_nx    = bus.alu_zero ? (pc_q + PC_W'(1) + dec.br_off) : (pc_q + PC_W'(1));
          state_nx = resume_st;
        end else begin
          we3_nx   = 1'b1;
          state_nx = ST_WB;
        end
      end
      ST_WB: begin
        pc_nx    = pc_q + PC_W'(1);
        state_nx = resume_st;
      end
`ifdef SEQ_SINGLE_STEP_EN
      ST_WAIT: begin
        if (step_rise) state_nx = ST_FETCH;
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
    busy_nx = (state_nx != ST_IDLE) && (state_nx != ST_HALT);
    done_nx = (state_nx == ST_HALT);
  end

  assign bus.pc       = pc_q;
  assign bus.rf_ra1   = ra1_q;
  assign bus.rf_ra2   = ra2_q;
  assign bus.rf_wa3   = wa3_q;
  assign bus.rf_we3   = we3_q;
  assign bus.alu_ctrl = ctrl_q;
  assign bus.alu_src  = src_q;
  assign bus.imm      = imm_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign state_dbg    = 3'(state_q);

endmodule
